lmsm_sequencer: RTL and testbench
=================================

Name: lmsm_sequencer

Overview:
- Multi-cycle controller for load-multiple (LM) and store-multiple (SM) instructions.
- Walks the set bits of an 8-bit register mask and emits, per transfer, the register index and the memory address.
- Drives memory and register-file strobes, and stalls the upstream pipeline stages until the block transfer completes.
- Sits beside the memory-access stage, between decode and the data memory / register-file write port.

Parameters:
- ADDR_W, 16, width of base and memory addresses.
- LM_OP, 4'b0110, opcode value for load-multiple.
- SM_OP, 4'b0111, opcode value for store-multiple.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  instruction valid in stage this cycle.
- opcode  input  4  instruction opcode.
- mask  input  8  register mask; bit i selects register Ri.
- base_addr  input  ADDR_W  start address (RF operand), sampled on accept.
- mem_ready  input  1  memory completes current beat this cycle.
- busy  output  1  sequencer not IDLE.
- stall  output  1  hold fetch/decode/operand stages.
- reg_idx  output  3  register for current beat.
- mem_addr  output  ADDR_W  address for current beat.
- mem_re  output  1  memory read strobe (LM beat).
- mem_we  output  1  memory write strobe (SM beat).
- rf_we  output  1  register-file write enable (LM beat completing).
- done  output  1  one-cycle pulse: block transfer finished.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Pending-mask, address counter and op-latch clear to 0.
  - All outputs 0; reg_idx=0, mem_addr=0.
- States: IDLE, RUN, DONE.
- Accept:
  - In IDLE, start=1 and opcode in {LM_OP, SM_OP} is an accept.
  - On accept, latch pending=mask, addr=base_addr, is_lm=(opcode==LM_OP).
  - Next state is RUN if mask!=0, else DONE.
  - Other opcodes, or start=0, leave the block in IDLE with no effect.
- stall:
  - Combinational.
  - High on the accept cycle in IDLE, throughout RUN, and in DONE.
  - Low otherwise.
- RUN:
  - reg_idx = index of the lowest set bit of pending (priority encoder, bit0 first).
  - mem_addr = addr.
  - mem_re = is_lm; mem_we = !is_lm; rf_we = is_lm & mem_ready.
  - Beat completes on a cycle with mem_ready=1: clear that bit in pending and set addr <= addr+1.
  - Address wraps modulo 2^ADDR_W (0xFFFF+1 -> 0x0000), no flag.
  - If the cleared bit was the last set bit, next state is DONE; otherwise stay in RUN.
  - mem_ready=0: hold pending, addr and all outputs unchanged (wait states unbounded).
- DONE:
  - done=1, stall=1, strobes 0, for exactly one cycle.
  - Then go to IDLE; stall releases the following cycle.
- Latency: N set bits with mem_ready tied high gives 1 accept cycle + N RUN cycles + 1 DONE cycle.
- Zero mask: accept, then DONE for one cycle; no memory or RF activity.
- start/opcode/mask/base_addr are ignored while busy. Upstream holds them under stall, but they are not re-sampled.
- busy = (state != IDLE). It is registered, so it is low in the accept cycle.
- Reset mid-RUN: the transfer is aborted immediately. No done pulse, strobes drop asynchronously.
- Outside RUN: reg_idx=0, mem_addr=0, mem_re/mem_we/rf_we=0.

Test Plan:
- LM, mask=8'b0000_0101, base=0x0040, mem_ready=1:
  - Beat 1: reg_idx=0, mem_addr=0x0040, mem_re=1, rf_we=1.
  - Beat 2: reg_idx=2, mem_addr=0x0041.
  - Then done pulse; stall high for 4 cycles total.
- SM, mask=8'hFF, base=0x1000, mem_ready=1:
  - reg_idx 0..7 at addresses 0x1000..0x1007 with mem_we=1, mem_re=0.
  - done in cycle 10 after accept cycle.
- LM, mask=8'b1000_0000, mem_ready low for 3 cycles then high:
  - reg_idx=7 and mem_addr held stable throughout.
  - rf_we only in the mem_ready cycle; done follows.
- Zero mask LM:
  - Accept -> DONE -> IDLE; stall high 2 cycles.
  - mem_re/mem_we/rf_we never asserted.
- SM, base=0xFFFF, mask=8'b0000_0011: addresses 0xFFFF then 0x0000 (wrap).
- SM, mask=8'hFF; rst_n low during 3rd beat:
  - All outputs 0 asynchronously, state IDLE, no done.
  - A new LM accepted on the first start after release.
  - start with opcode 4'b0000 produces no activity.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// lmsm_sequencer
//
// Multi-cycle controller for load-multiple (LM) and store-multiple (SM)
// instructions. An accepted instruction latches an 8-bit register mask and a
// base address. The block then walks the set bits of the mask, lowest bit
// first. Each transfer ("beat") presents a register index and a memory
// address. The upstream pipeline is stalled until the block transfer ends.
//
// Beat handshake: during RUN the sequencer presents a beat (reg_idx, mem_addr,
// and mem_re or mem_we). That beat stays stable until a cycle in which
// mem_ready=1. That cycle completes the beat, and the next beat (or DONE)
// follows on the next clock. There is no bound on the number of wait cycles.
// rf_we is asserted only in the completing cycle of an LM beat.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   instruction valid in stage this cycle
//   opcode     in   [3:0] instruction opcode
//   mask       in   [7:0] register mask, bit i selects Ri
//   base_addr  in   [ADDR_W-1:0] start address, sampled on accept
//   mem_ready  in   memory completes current beat this cycle
//   busy       out  sequencer not IDLE (registered state)
//   stall      out  hold fetch/decode/operand stages
//   reg_idx    out  [2:0] register for current beat
//   mem_addr   out  [ADDR_W-1:0] address for current beat
//   mem_re     out  memory read strobe (LM beat)
//   mem_we     out  memory write strobe (SM beat)
//   rf_we      out  register-file write enable (LM beat completing)
//   done       out  one-cycle pulse, block transfer finished
//   dbg_state  out  [1:0] current FSM state (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------
module lmsm_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter logic [3:0]  LM_OP  = 4'b0110,
  parameter logic [3:0]  SM_OP  = 4'b0111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [7:0]        mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              stall,
  output logic [2:0]        reg_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic              rf_we,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_pending;
  logic [ADDR_W-1:0] r_addr;
  logic              r_is_lm;

  logic              w_accept;
  logic              w_is_op;
  logic [2:0]        w_idx;
  logic [7:0]        w_remaining;
  logic              w_beat_done;

  assign w_is_op  = (opcode == LM_OP) || (opcode == SM_OP);
  assign w_accept = (r_state == S_IDLE) && start && w_is_op;

  // Lowest set bit of the pending mask. The loop runs from the top down, so
  // the lowest set bit is the last one written and therefore wins.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_idx = 3'(i);
      end
    end
  end

  assign w_remaining = r_pending & ~(8'b0000_0001 << w_idx);
  assign w_beat_done = (r_state == S_RUN) && mem_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (mask != 8'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (mem_ready && (w_remaining == 8'd0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: the operands are captured only on accept. While the block is
  // busy, new upstream values are never re-sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 8'd0;
      r_addr    <= '0;
      r_is_lm   <= 1'b0;
    end else if (w_accept) begin
      r_pending <= mask;
      r_addr    <= base_addr;
      r_is_lm   <= (opcode == LM_OP);
    end else if (w_beat_done) begin
      r_pending <= w_remaining;
      r_addr    <= r_addr + 1'b1;  // wraps modulo 2^ADDR_W
    end
  end

  // Outputs are decoded from the state. Reset forces IDLE asynchronously,
  // so the strobes drop as soon as rst_n goes low.
  always_comb begin
    busy     = 1'b0;
    stall    = 1'b0;
    reg_idx  = 3'd0;
    mem_addr = '0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_accept;
      end
      S_RUN: begin
        busy     = 1'b1;
        stall    = 1'b1;
        reg_idx  = w_idx;
        mem_addr = r_addr;
        mem_re   = r_is_lm;
        mem_we   = !r_is_lm;
        rf_we    = r_is_lm && mem_ready;
      end
      S_DONE: begin
        busy  = 1'b1;
        stall = 1'b1;
        done  = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lmsm_sequencer
//
// Directed testbench for lmsm_sequencer. Inputs change just after the falling
// edge. Outputs are sampled 2 ns later, which is well before the next rising
// edge. Each task checks its own scenario cycle by cycle against hand-computed
// values.
// Output vector layout used in the checks:
//   {busy, stall, reg_idx[2:0], mem_addr[15:0], mem_re, mem_we, rf_we, done}
// -----------------------------------------------------------------------------
module tb_lmsm_sequencer;

  localparam logic [3:0] LM = 4'b0110;
  localparam logic [3:0] SM = 4'b0111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [7:0]  mask;
  logic [15:0] base_addr;
  logic        mem_ready;
  logic        busy;
  logic        stall;
  logic [2:0]  reg_idx;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic        rf_we;
  logic        done;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  lmsm_sequencer #(
    .ADDR_W(16),
    .LM_OP (LM),
    .SM_OP (SM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .mask     (mask),
    .base_addr(base_addr),
    .mem_ready(mem_ready),
    .busy     (busy),
    .stall    (stall),
    .reg_idx  (reg_idx),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .rf_we    (rf_we),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] obs();
    return {busy, stall, reg_idx, mem_addr, mem_re, mem_we, rf_we, done};
  endfunction

  function automatic logic [24:0] ev(input logic b, input logic st,
                                     input logic [2:0] idx, input logic [15:0] a,
                                     input logic re, input logic we,
                                     input logic rw, input logic dn);
    return {b, st, idx, a, re, we, rw, dn};
  endfunction

  // Driver: apply one cycle's inputs after the falling edge, then wait 2 ns.
  task automatic drive(input logic s, input logic [3:0] op, input logic [7:0] m,
                       input logic [15:0] b, input logic rdy);
    @(negedge clk);
    start     = s;
    opcode    = op;
    mask      = m;
    base_addr = b;
    mem_ready = rdy;
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b0);
    total++;
    if (obs() !== ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL reset_outs got=%h exp=%h", obs(), ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
    total++;
    if (dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lm_two();
    // accept cycle
    drive(1'b1, LM, 8'b0000_0101, 16'h0040, 1'b1);
    total++;
    if (obs() !== ev(0, 1, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL lm2_accept got=%h exp=%h", obs(), ev(0, 1, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
    // beat 1, with unrelated upstream values present (must be ignored)
    drive(1'b1, SM, 8'hFF, 16'h1234, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd0, 16'h0040, 1, 0, 1, 0)) begin
      bad++;
      $display("FAIL lm2_beat1 got=%h exp=%h", obs(), ev(1, 1, 3'd0, 16'h0040, 1, 0, 1, 0));
    end
    drive(1'b1, SM, 8'hF0, 16'h0000, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd2, 16'h0041, 1, 0, 1, 0)) begin
      bad++;
      $display("FAIL lm2_beat2 got=%h exp=%h", obs(), ev(1, 1, 3'd2, 16'h0041, 1, 0, 1, 0));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1)) begin
      bad++;
      $display("FAIL lm2_done got=%h exp=%h", obs(), ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL lm2_idle got=%h exp=%h", obs(), ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
  endtask

  task automatic test_sm_full();
    logic [15:0] a;
    drive(1'b1, SM, 8'hFF, 16'h1000, 1'b1);
    total++;
    if (obs() !== ev(0, 1, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL smff_accept got=%h exp=%h", obs(), ev(0, 1, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
      a = 16'h1000 + 16'(i);
      total++;
      if (obs() !== ev(1, 1, 3'(i), a, 0, 1, 0, 0)) begin
        bad++;
        $display("FAIL smff_beat%0d got=%h exp=%h", i, obs(), ev(1, 1, 3'(i), a, 0, 1, 0, 0));
      end
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1)) begin
      bad++;
      $display("FAIL smff_done got=%h exp=%h", obs(), ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL smff_idle got=%h exp=%h", obs(), ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
  endtask

  task automatic test_wait_states();
    drive(1'b1, LM, 8'b1000_0000, 16'h0020, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b0);
      total++;
      if (obs() !== ev(1, 1, 3'd7, 16'h0020, 1, 0, 0, 0)) begin
        bad++;
        $display("FAIL wait_hold%0d got=%h exp=%h", i, obs(), ev(1, 1, 3'd7, 16'h0020, 1, 0, 0, 0));
      end
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd7, 16'h0020, 1, 0, 1, 0)) begin
      bad++;
      $display("FAIL wait_ready got=%h exp=%h", obs(), ev(1, 1, 3'd7, 16'h0020, 1, 0, 1, 0));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b0);
    total++;
    if (obs() !== ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1)) begin
      bad++;
      $display("FAIL wait_done got=%h exp=%h", obs(), ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b0);
  endtask

  task automatic test_zero_mask();
    drive(1'b1, LM, 8'h00, 16'h0300, 1'b1);
    total++;
    if (obs() !== ev(0, 1, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL zero_accept got=%h exp=%h", obs(), ev(0, 1, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1)) begin
      bad++;
      $display("FAIL zero_done got=%h exp=%h", obs(), ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL zero_idle got=%h exp=%h", obs(), ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, SM, 8'b0000_0011, 16'hFFFF, 1'b1);
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd0, 16'hFFFF, 0, 1, 0, 0)) begin
      bad++;
      $display("FAIL wrap_beat1 got=%h exp=%h", obs(), ev(1, 1, 3'd0, 16'hFFFF, 0, 1, 0, 0));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd1, 16'h0000, 0, 1, 0, 0)) begin
      bad++;
      $display("FAIL wrap_beat2 got=%h exp=%h", obs(), ev(1, 1, 3'd1, 16'h0000, 0, 1, 0, 0));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1)) begin
      bad++;
      $display("FAIL wrap_done got=%h exp=%h", obs(), ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    drive(1'b1, SM, 8'hFF, 16'h0200, 1'b1);
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd2, 16'h0202, 0, 1, 0, 0)) begin
      bad++;
      $display("FAIL rst_beat3 got=%h exp=%h", obs(), ev(1, 1, 3'd2, 16'h0202, 0, 1, 0, 0));
    end
    // assert reset between edges: outputs must drop without a clock
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL rst_async got=%h exp=%h", obs(), ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
    total++;
    if (dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL rst_state got=%0d exp=0", dbg_state);
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    // no done pulse may appear after the abort
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL rst_nodone got=%h exp=%h", obs(), ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
    // non-LM/SM opcode has no effect
    drive(1'b1, 4'b0000, 8'hFF, 16'h0500, 1'b1);
    total++;
    if (obs() !== ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL badop_cycle got=%h exp=%h", obs(), ev(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
    // new LM, accepted on the first valid start after release
    drive(1'b1, LM, 8'b0000_0001, 16'h0010, 1'b1);
    total++;
    if (obs() !== ev(0, 1, 3'd0, 16'h0000, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL post_accept got=%h exp=%h", obs(), ev(0, 1, 3'd0, 16'h0000, 0, 0, 0, 0));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd0, 16'h0010, 1, 0, 1, 0)) begin
      bad++;
      $display("FAIL post_beat got=%h exp=%h", obs(), ev(1, 1, 3'd0, 16'h0010, 1, 0, 1, 0));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
    total++;
    if (obs() !== ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1)) begin
      bad++;
      $display("FAIL post_done got=%h exp=%h", obs(), ev(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1));
    end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 1'b1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    opcode    = 4'd0;
    mask      = 8'd0;
    base_addr = 16'd0;
    mem_ready = 1'b0;
    test_reset();
    test_lm_two();
    test_sm_full();
    test_wait_states();
    test_zero_mask();
    test_wrap();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
